// File: rtl/hazard_ctrl_pkg.sv
// Purpose: shared types and constants for the pipeline hazard controller.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_STARTUP,
    HZ_RUN,
    HZ_MEM_WAIT
  } hz_state_t;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  // Larger of two sizing parameters; used to size the shared cycle counter.
  function automatic int hz_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Purpose: free-running stall / redirect-flush event counters for the hazard controller.
// Latency: a counter reflects an event one cycle after the event cycle; wraps at 2^CNT_W.
// Backpressure: none; it counts every qualified cycle and never stalls anything.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  // Count qualified stall and redirect-flush cycles, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_inc) perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (flush_inc) perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: stall/flush sequencing for the 5-stage pipe (reset drain, mem waits, load-use, redirects).
//          Optional perf counters compiled in with `define HAZARD_PERF_CNT_EN.
// Latency: stall/flush outputs are combinational from state + inputs; mem_timeout is registered.
// Backpressure: a pending data access (mem_req && !mem_ready) freezes PC..EX/MEM and bubbles MEM/WB.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RST_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT      = 64,
  parameter int CNT_W            = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic [6:0] ex_opcode,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       mem_wb_flush,
  output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  // One counter serves both the startup drain and the mem-wait timeout.
  localparam int CW = $clog2(hz_max(RST_FLUSH_CYCLES, MEM_TIMEOUT) + 1);
  localparam logic [CW-1:0] STARTUP_LAST = CW'(RST_FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_V    = CW'(MEM_TIMEOUT);

  hz_state_t       state;
  logic [CW-1:0]   cnt;
  logic            mem_stall;
  logic            load_use;
  logic            rs1_hit;
  logic            rs2_hit;

  // Hazard detection terms; rd==x0 never creates a dependency.
  always_comb begin
    rs1_hit   = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit   = id_use_rs2 && (id_rs2 == ex_rd);
    load_use  = (ex_opcode == OPC_LOAD) && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    mem_stall = ((state == HZ_RUN) && mem_req && !mem_ready) ||
                ((state == HZ_MEM_WAIT) && !mem_ready);
  end

  // Output decode: startup drain, then mem stall > redirect > load-use.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (state == HZ_STARTUP) begin
      pc_stall     = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_stall) begin
      // EX is frozen here, so a redirect in EX is simply presented again on release.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      // Single bubble: next cycle the load is in MEM and forwarding covers the use.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_flush  = 1'b1;
    end
  end

  // Sequencing FSM with the cycle counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HZ_STARTUP;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        HZ_STARTUP: begin
          if (cnt == STARTUP_LAST) begin
            state <= HZ_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HZ_RUN: begin
          if (mem_req && !mem_ready) begin
            state <= HZ_MEM_WAIT;
            cnt   <= CW'(1);
          end
        end
        HZ_MEM_WAIT: begin
          if (mem_ready) begin
            state <= HZ_RUN;
            cnt   <= '0;
          end else begin
            // Keep waiting forever; the flag only reports the overrun.
            if (cnt != TIMEOUT_V) cnt <= cnt + CW'(1);
            if (cnt == TIMEOUT_V) mem_timeout <= 1'b1;
          end
        end
        default: begin
          state <= HZ_STARTUP;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  // Count only post-startup stalls and redirects that actually flush.
  always_comb begin
    stall_inc = (state != HZ_STARTUP) && pc_stall;
    flush_inc = (state != HZ_STARTUP) && !mem_stall && ex_redirect;
  end

  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_inc     (stall_inc),
    .flush_inc     (flush_inc),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: directed-vector scoreboard bench for hazard_ctrl (RST_FLUSH_CYCLES=2, MEM_TIMEOUT=4).
// Latency: driver applies inputs 1ns after posedge; monitor compares at the following negedge.
// Backpressure: n/a.
module tb_hazard_ctrl;

  localparam logic [7:0] E_IDLE  = 8'b0000_0000;
  localparam logic [7:0] E_START = 8'b1010_1010;
  localparam logic [7:0] E_MEMST = 8'b1101_0110;
  localparam logic [7:0] E_LU    = 8'b1100_1000;
  localparam logic [7:0] E_RD    = 8'b0010_1000;
  localparam logic [7:0] E_TO    = 8'b0000_0001;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2;
  logic [6:0] ex_opcode;
  logic       ex_redirect, mem_req, mem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, mem_wb_flush, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int exp_stalls = 0;
  int exp_flushes = 0;

  hazard_ctrl #(
    .RST_FLUSH_CYCLES(2),
    .MEM_TIMEOUT     (4),
    .CNT_W           (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_opcode   (ex_opcode),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_stall    (pc_stall),
    .if_id_stall (if_id_stall),
    .if_id_flush (if_id_flush),
    .id_ex_stall (id_ex_stall),
    .id_ex_flush (id_ex_flush),
    .ex_mem_stall(ex_mem_stall),
    .mem_wb_flush(mem_wb_flush),
    .mem_timeout (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Push this cycle's expected outputs, then advance to just after the next posedge.
  task automatic chk(input logic [7:0] e, input string nm);
    sb_item_t it;
    it.exp  = e;
    it.name = nm;
    sb_q.push_back(it);
    if (!rst_n) begin
      exp_stalls  = 0;
      exp_flushes = 0;
    end else if ((e & 8'hFE) != E_START) begin
      if (e[7]) exp_stalls++;
      if ((e & 8'hFE) == E_RD) exp_flushes++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_opcode = 7'd0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu();
    ex_opcode = 7'b0000011; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
  endtask

  // Monitor: compares DUT outputs against the oldest expectation each cycle.
  initial begin
    logic [7:0] act;
    sb_item_t   it;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, mem_timeout};
        n_chk++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %b required %b (pc,ifs,iff,ids,idf,ems,mwf,to)",
                   it.name, act, it.exp);
        end
      end
    end
  end

  // Driver: directed vectors.
  initial begin
    rst_n = 1'b0;
    clr();
    @(posedge clk);
    #1;
    chk(E_START, "reset_a");
    chk(E_START, "reset_b");
    rst_n = 1'b1;
    chk(E_START, "drain_0");
    chk(E_START, "drain_1");
    chk(E_IDLE,  "run_idle");

    set_lu();
    chk(E_LU,    "lu_rs2");
    clr();
    chk(E_IDLE,  "lu_gone");
    set_lu(); ex_rd = 5'd0; id_rs2 = 5'd0;
    chk(E_IDLE,  "lu_x0");
    clr(); ex_opcode = 7'b0000011; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    chk(E_LU,    "lu_rs1");
    id_use_rs1 = 1'b0;
    chk(E_IDLE,  "lu_rs1_unused");
    id_use_rs1 = 1'b1; ex_opcode = 7'b0110011;
    chk(E_IDLE,  "nonload_match");
    clr();

    ex_redirect = 1'b1;
    chk(E_RD,    "redirect");
    ex_redirect = 1'b0;
    chk(E_IDLE,  "redirect_gone");
    set_lu(); ex_redirect = 1'b1;
    chk(E_RD,    "redirect_over_lu");
    clr();

    mem_req = 1'b1; mem_ready = 1'b1;
    chk(E_IDLE,  "mem_zero_wait");
    mem_ready = 1'b0;
    chk(E_MEMST, "memwait_0");
    chk(E_MEMST, "memwait_1");
    chk(E_MEMST, "memwait_2");
    mem_ready = 1'b1;
    chk(E_IDLE,  "mem_release");
    clr();
    chk(E_IDLE,  "mem_after");

    mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1; set_lu();
    chk(E_MEMST, "combo_run");
    chk(E_MEMST, "combo_wait");
    mem_ready = 1'b1;
    chk(E_RD,    "combo_release");
    clr();
    chk(E_IDLE,  "combo_after");

    mem_req = 1'b1; mem_ready = 1'b0;
    chk(E_MEMST, "to_run");
    chk(E_MEMST, "to_wait1");
    chk(E_MEMST, "to_wait2");
    chk(E_MEMST, "to_wait3");
    chk(E_MEMST, "to_wait4");
    chk(E_MEMST | E_TO, "to_set");
    mem_ready = 1'b1;
    chk(E_TO,    "to_release");
    clr();
    chk(E_TO,    "to_sticky_a");
    chk(E_TO,    "to_sticky_b");

    rst_n = 1'b0;
    chk(E_START, "midrst");
    rst_n = 1'b1;
    chk(E_START, "redrain_0");
    chk(E_START, "redrain_1");
    ex_redirect = 1'b1;
    chk(E_RD,    "redirect_post_rst");
    clr();
    chk(E_IDLE,  "final_idle");

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_queue: %0d entries left, required 0", sb_q.size());
    end

`ifdef HAZARD_PERF_CNT_EN
    n_chk++;
    if (perf_stall_cnt !== 32'(exp_stalls)) begin
      n_fail++;
      $display("FAIL perf_stall: got %0d required %0d", perf_stall_cnt, exp_stalls);
    end
    n_chk++;
    if (perf_flush_cnt !== 32'(exp_flushes)) begin
      n_fail++;
      $display("FAIL perf_flush: got %0d required %0d", perf_flush_cnt, exp_flushes);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
